// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one single-byte I2C write master
// between N_REQ requesters. Latches the winner's address/data, runs the
// master's ena/busy handshake and returns a per-requester done/err pulse.
module i2c_bus_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ISSUE_TIMEOUT = 4096,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               m_ena,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_data,
  input  logic               m_busy,
  input  logic               m_ack_error,
  output logic               active
);

  localparam int unsigned TO_W  = (ISSUE_TIMEOUT > 1) ? $clog2(ISSUE_TIMEOUT) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               m_ena_q, m_ena_d;
  logic [6:0]         m_addr_q, m_addr_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               active_q, active_d;
  // rr pointer kept one-hot: the bit of the most recently granted requester
  logic [N_REQ-1:0]   rr_q, rr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0]   rr_mask;
  logic [N_REQ-1:0]   req_hi;
  logic [N_REQ-1:0]   pick;
  logic [6:0]         pick_addr;
  logic [7:0]         pick_data;
  logic               to_last;
  logic               gap_last;

  // Round-robin pick: lowest request above the pointer, else lowest overall
  always_comb begin
    rr_mask   = ~((rr_q << 1) - N_REQ'(1));
    req_hi    = req & rr_mask;
    pick      = (|req_hi) ? (req_hi & (~req_hi + N_REQ'(1)))
                          : (req & (~req + N_REQ'(1)));
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick[i]) begin
        pick_addr = req_addr[7*i +: 7];
        pick_data = req_data[8*i +: 8];
      end
    end
  end

  // Terminal-count decodes for the issue timeout and the inter-transfer gap
  always_comb begin
    to_last  = (32'(to_cnt_q) == (ISSUE_TIMEOUT - 1));
    gap_last = (GAP_CYCLES == 0) || (32'(gap_cnt_q) == (GAP_CYCLES - 1));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    m_ena_d   = m_ena_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    rr_d      = rr_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if ((|req) && !m_busy) begin
          gnt_d    = pick;
          rr_d     = pick;
          m_addr_d = pick_addr;
          m_data_d = pick_data;
          m_ena_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A busy arriving on the timeout cycle still counts as a start
        if (m_busy) begin
          m_ena_d = 1'b0;
          state_d = ST_BUSY;
        end else if (to_last) begin
          m_ena_d   = 1'b0;
          done_d    = gnt_q;
          err_d     = gnt_q;
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_BUSY: begin
        if (!m_busy) begin
          done_d    = gnt_q;
          err_d     = m_ack_error ? gnt_q : '0;
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_last) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State and output registers; rr pointer resets so requester 0 wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      m_ena_q   <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      active_q  <= 1'b0;
      rr_q      <= {1'b1, {(N_REQ-1){1'b0}}};
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_ena_q   <= m_ena_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      active_q  <= active_d;
      rr_q      <= rr_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign m_ena  = m_ena_q;
  assign m_addr = m_addr_q;
  assign m_data = m_data_q;
  assign active = active_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a simple I2C master model.
module tb_i2c_bus_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 64;
  localparam int unsigned GAP = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  gnt, done, err;
  logic          m_ena;
  logic [6:0]    m_addr;
  logic [7:0]    m_data;
  logic          m_busy = 1'b0;
  logic          m_ack_error = 1'b0;
  logic          active;

  i2c_bus_arbiter #(
    .N_REQ(N), .ISSUE_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .done(done), .err(err),
    .m_ena(m_ena), .m_addr(m_addr), .m_data(m_data), .m_busy(m_busy),
    .m_ack_error(m_ack_error), .active(active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {int idx; bit err; int cyc;} ev_t;
  ev_t grant_q[$];
  ev_t done_q[$];
  int  cyc = 0;
  int  ena_run = 0;
  int  last_ena_len = 0;
  logic [N-1:0] prev_gnt = '0;

  // master model knobs
  int mdl_delay = 3;
  int mdl_len   = 200;
  bit mdl_never_busy = 1'b0;
  bit mdl_ack_err    = 1'b0;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // event recorder and invariant checks
  always @(negedge clk) begin
    ev_t e;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("done_onehot0", 32'($onehot0(done)), 32'd1);
    chk("err_without_done", 32'(|(err & ~done)), 32'd0);
    if (|done) begin
      e.idx = oh_idx(done); e.err = |(err & done); e.cyc = cyc;
      done_q.push_back(e);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      e.idx = oh_idx(gnt); e.err = 1'b0; e.cyc = cyc;
      grant_q.push_back(e);
    end
    prev_gnt = gnt;
    if (m_ena) ena_run++;
    else if (ena_run != 0) begin
      last_ena_len = ena_run;
      ena_run = 0;
    end
  end

  // I2C master model: busy mdl_delay cycles after ena, for mdl_len cycles
  initial begin
    int st = 0;
    int c  = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        st = 0; m_busy = 1'b0; m_ack_error = 1'b0;
      end else begin
        case (st)
          0: if (m_ena && !mdl_never_busy) begin c = 0; st = 1; end
          1: begin
            c++;
            if (c >= mdl_delay) begin m_busy = 1'b1; c = 0; st = 2; end
          end
          2: begin
            c++;
            if (c >= mdl_len) begin
              m_busy = 1'b0; m_ack_error = mdl_ack_err; mdl_ack_err = 1'b0; st = 3;
            end
          end
          default: begin m_ack_error = 1'b0; st = 0; end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = '0;
    mdl_never_busy = 1'b0; mdl_ack_err = 1'b0; mdl_len = 200;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_ena", 32'(m_ena), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    done_q.delete(); grant_q.delete();
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string tag);
    int n = 0;
    while (m_busy !== lvl && n < lim) begin @(negedge clk); n++; end
    chk(tag, 32'(m_busy), 32'(lvl));
  endtask

  task automatic wait_done_n(input int n, input int lim, input string tag);
    int k = 0;
    while (done_q.size() < n && k < lim) begin @(negedge clk); k++; end
    chk(tag, 32'(done_q.size()), 32'(n));
  endtask

  task automatic chk_done(input int n, input int idx, input bit e, input string tag);
    if (done_q.size() <= n) chk({tag, "_missing"}, 32'(done_q.size()), 32'(n + 1));
    else begin
      chk({tag, "_idx"}, 32'(done_q[n].idx), 32'(idx));
      chk({tag, "_err"}, 32'(done_q[n].err), 32'(e));
    end
  endtask

  task automatic chk_grant(input int n, input int idx, input string tag);
    if (grant_q.size() <= n) chk({tag, "_missing"}, 32'(grant_q.size()), 32'(n + 1));
    else chk({tag, "_idx"}, 32'(grant_q[n].idx), 32'(idx));
  endtask

  initial begin
    int exp2 [6] = '{0, 1, 3, 0, 1, 3};

    // T1: single transfer, latency, latching, handshake
    do_reset();
    req_addr[6:0] = 7'h27; req_data[7:0] = 8'h3C; req = 4'b0001;
    chk("t1_no_gnt_before_edge", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_m_ena", 32'(m_ena), 32'd1);
    chk("t1_m_addr", 32'(m_addr), 32'h27);
    chk("t1_m_data", 32'(m_data), 32'h3C);
    chk("t1_active", 32'(active), 32'd1);
    req_addr[6:0] = 7'h55; req_data[7:0] = 8'hAA;
    wait_busy(1'b1, 20, "t1_busy_rise");
    chk("t1_ena_before_busy_seen", 32'(m_ena), 32'd1);
    @(negedge clk);
    chk("t1_ena_drop", 32'(m_ena), 32'd0);
    chk("t1_gnt_held", 32'(gnt), 32'b0001);
    wait_busy(1'b0, 300, "t1_busy_fall");
    chk("t1_no_done_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'b0001);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_gnt_clear", 32'(gnt), 32'd0);
    chk("t1_addr_stable", 32'(m_addr), 32'h27);
    chk("t1_data_stable", 32'(m_data), 32'h3C);
    req = '0;
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // T2: round-robin order and gap
    do_reset();
    mdl_len = 20;
    req = 4'b1011;
    wait_done_n(6, 3000, "t2_six_done");
    req = '0;
    for (int i = 0; i < 6; i++) begin
      chk_grant(i, exp2[i], $sformatf("t2_grant%0d", i));
      chk_done(i, exp2[i], 1'b0, $sformatf("t2_done%0d", i));
    end
    if (grant_q.size() >= 6 && done_q.size() >= 6)
      for (int i = 0; i < 5; i++)
        chk($sformatf("t2_gap%0d", i),
            32'((grant_q[i+1].cyc - done_q[i].cyc - 1) >= int'(GAP)), 32'd1);

    // T3: issue timeout, then next requester served normally
    do_reset();
    mdl_never_busy = 1'b1; mdl_len = 20;
    req = 4'b0011;
    wait_done_n(1, 200, "t3_timeout_done");
    mdl_never_busy = 1'b0;
    req = 4'b0010;
    @(negedge clk);
    chk("t3_ena_len", 32'(last_ena_len), 32'(TO));
    chk_done(0, 0, 1'b1, "t3_done0");
    wait_done_n(2, 300, "t3_second_done");
    req = '0;
    chk_grant(1, 1, "t3_grant1");
    chk_done(1, 1, 1'b0, "t3_done1");

    // T4: ack error reported, following transfer clean
    do_reset();
    mdl_len = 20; mdl_ack_err = 1'b1;
    req = 4'b0100;
    wait_done_n(1, 200, "t4_first_done");
    req = 4'b1000;
    wait_done_n(2, 300, "t4_second_done");
    req = '0;
    chk_done(0, 2, 1'b1, "t4_done0");
    chk_done(1, 3, 1'b0, "t4_done1");
    chk_grant(1, 3, "t4_grant1");

    // T5: req dropped during BUSY; short req pulse never granted
    do_reset();
    mdl_len = 20;
    req = 4'b0100;
    wait_busy(1'b1, 20, "t5_busy_rise");
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    req = '0;
    wait_done_n(1, 100, "t5_done");
    repeat (GAP + 20) @(negedge clk);
    chk("t5_done_count", 32'(done_q.size()), 32'd1);
    chk("t5_grant_count", 32'(grant_q.size()), 32'd1);
    chk_done(0, 2, 1'b0, "t5_done0");
    chk("t5_idle_gnt", 32'(gnt), 32'd0);
    chk("t5_idle_active", 32'(active), 32'd0);

    // T6: reset during BUSY
    do_reset();
    mdl_len = 200;
    req = 4'b0010;
    wait_busy(1'b1, 20, "t6_busy_rise");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_m_ena", 32'(m_ena), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_active", 32'(active), 32'd0);
    chk("t6_m_addr", 32'(m_addr), 32'd0);
    done_q.delete(); grant_q.delete();
    repeat (3) @(posedge clk);
    #1;
    req = 4'b0001;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_regrant0", 32'(gnt), 32'b0001);
    chk("t6_ena", 32'(m_ena), 32'd1);
    chk("t6_no_abort_done", 32'(done_q.size()), 32'd0);
    mdl_len = 20;
    wait_done_n(1, 400, "t6_done");
    req = '0;
    chk_done(0, 0, 1'b0, "t6_done0");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
